// File: rtl/data_mem_bytelane_if.sv
// Request/response bundle between the MEM stage and the byte-lane data memory.
// The master drives loads/stores; the slave answers with read data and status strobes.
interface data_mem_bytelane_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  memRead;
    logic                  memWrite;
    logic [1:0]            mem_size;
    logic                  mem_unsigned;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  rd_valid;
    logic                  mem_err;
    logic                  busy;

    modport master (
        output mem_addr, write_data, memRead, memWrite, mem_size, mem_unsigned,
        input  read_data, rd_valid, mem_err, busy
    );

    modport slave (
        input  mem_addr, write_data, memRead, memWrite, mem_size, mem_unsigned,
        output read_data, rd_valid, mem_err, busy
    );
endinterface

// File: rtl/data_mem_bytelane.sv
// Byte-addressable little-endian data memory: byte/half/word loads and stores, sign/zero-extended loads.
// Latency: load data or error strobe appears READ_LATENCY (1 or 2) edges after the accept edge.
// Backpressure: none; one request per cycle is taken whenever busy is low (busy only around reset).
module data_mem_bytelane #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_BYTES  = 64,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input logic                clk,
    input logic                reset,
    data_mem_bytelane_if.slave bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam logic [IDX_W:0]      DEPTH_L = (IDX_W + 1)'(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH_BYTES);

    typedef struct packed {
        logic                  ld_vld;
        logic                  err;
        logic [DATA_WIDTH-1:0] dat;
    } resp_t;

    logic [7:0]       mem [DEPTH_BYTES];
    logic             busy_q;
    logic [3:0]       size_bytes;
    logic [2:0]       align_mask;
    logic             size_bad;
    logic             req;
    logic             req_err;
    logic             ld_ok;
    logic             st_ok;
    logic [IDX_W-1:0] lane_idx [NB];
    logic [7:0]       raw_byte [NB];
    logic             sign_bit;
    logic [DATA_WIDTH-1:0] ld_dat;
    resp_t            pipe_q [READ_LATENCY];

    always_comb begin
        size_bytes = 4'(NB);
        align_mask = 3'(NB - 1);
        size_bad   = 1'b0;
        case (bus.mem_size)
            2'b00: begin
                size_bytes = 4'd1;
                align_mask = 3'd0;
            end
            2'b01: begin
                size_bytes = 4'd2;
                align_mask = 3'd1;
            end
            2'b10: ;
            default: size_bad = 1'b1;
        endcase
    end

    // Range check is done one bit wider so addresses near the top of the space cannot wrap.
    assign req     = ~busy_q & (bus.memRead | bus.memWrite);
    assign req_err = (bus.memRead & bus.memWrite) | size_bad
                   | (|(bus.mem_addr[2:0] & align_mask))
                   | (({1'b0, bus.mem_addr} + (ADDR_WIDTH + 1)'(size_bytes)) > DEPTH_A);
    assign ld_ok   = req & ~req_err & bus.memRead;
    assign st_ok   = req & ~req_err & bus.memWrite;

    always_comb begin
        sign_bit = 1'b0;
        for (int i = 0; i < NB; i++) begin
            lane_idx[i] = bus.mem_addr[IDX_W-1:0] + IDX_W'(i);
            raw_byte[i] = ((4'(i) < size_bytes) && ({1'b0, lane_idx[i]} < DEPTH_L))
                        ? mem[lane_idx[i]] : 8'h00;
        end
        case (bus.mem_size)
            2'b00:   sign_bit = raw_byte[0][7];
            2'b01:   sign_bit = raw_byte[1][7];
            default: sign_bit = raw_byte[NB-1][7];
        endcase
        for (int i = 0; i < NB; i++) begin
            ld_dat[8*i +: 8] = (4'(i) < size_bytes) ? raw_byte[i]
                                                     : {8{sign_bit & ~bus.mem_unsigned}};
        end
    end

    always_ff @(posedge clk) begin
        busy_q <= reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH_BYTES; k++) begin
                mem[k] <= 8'h00;
            end
        end else if (st_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (4'(i) < size_bytes) begin
                    mem[lane_idx[i]] <= bus.write_data[8*i +: 8];
                end
            end
        end
    end

    // Data registers only load on a valid load so read_data holds between loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0].ld_vld <= ld_ok;
            pipe_q[0].err    <= req & req_err;
            if (ld_ok) begin
                pipe_q[0].dat <= ld_dat;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_q[k].ld_vld <= pipe_q[k-1].ld_vld;
                pipe_q[k].err    <= pipe_q[k-1].err;
                if (pipe_q[k-1].ld_vld) begin
                    pipe_q[k].dat <= pipe_q[k-1].dat;
                end
            end
        end
    end

    assign bus.read_data = pipe_q[READ_LATENCY-1].dat;
    assign bus.rd_valid  = pipe_q[READ_LATENCY-1].ld_vld;
    assign bus.mem_err   = pipe_q[READ_LATENCY-1].err;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_data_mem_bytelane.sv
// Drives a 32-bit/latency-1 and a 64-bit/latency-2 instance with identical requests
// and compares both against a byte-array reference model.
module tb_data_mem_bytelane;
    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_addr;
    logic [63:0] a_wd;
    logic        a_rd, a_wr, a_un;
    logic [1:0]  a_size;

    always #5 clk = ~clk;

    data_mem_bytelane_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b32 ();
    data_mem_bytelane_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) b64 ();

    assign b32.mem_addr = a_addr;  assign b32.write_data = a_wd[31:0];
    assign b32.memRead = a_rd;     assign b32.memWrite = a_wr;
    assign b32.mem_size = a_size;  assign b32.mem_unsigned = a_un;
    assign b64.mem_addr = a_addr;  assign b64.write_data = a_wd;
    assign b64.memRead = a_rd;     assign b64.memWrite = a_wr;
    assign b64.mem_size = a_size;  assign b64.mem_unsigned = a_un;

    data_mem_bytelane #(.DATA_WIDTH(32), .DEPTH_BYTES(64), .ADDR_WIDTH(32), .READ_LATENCY(1))
        u32 (.clk(clk), .reset(reset), .bus(b32.slave));
    data_mem_bytelane #(.DATA_WIDTH(64), .DEPTH_BYTES(64), .ADDR_WIDTH(32), .READ_LATENCY(2))
        u64 (.clk(clk), .reset(reset), .bus(b64.slave));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: index 0 = 32-bit/lat-1 instance, index 1 = 64-bit/lat-2 instance.
    logic [7:0]  mdl [2][64];
    logic        mbusy = 1'b1;
    bit          e_vld [2][N];
    bit          e_err [2][N];
    logic [63:0] e_dat [2][N];
    bit          e_busy [N];
    logic        o_vld [2][N];
    logic        o_err [2][N];
    logic        o_busy [2][N];
    logic [63:0] o_dat [2][N];

    task automatic cycle(input logic rst, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [63:0] wd, input logic un);
        int s, idx;
        logic [63:0] val;
        bit bad;
        if (cyc >= N - 2) begin
            $display("FAIL cycle_budget used %0d limit %0d", cyc, N - 2);
            $fatal(1, "cycle budget exhausted");
        end
        reset = rst; a_rd = rd; a_wr = wr; a_size = sz; a_addr = ad; a_wd = wd; a_un = un;
        e_busy[cyc] = rst;
        for (int k = 0; k < 2; k++) begin
            s = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4 * (k + 1);
            if (rst) begin
                for (int b = 0; b < 64; b++) mdl[k][b] = 8'h00;
                e_vld[k][cyc] = 1'b0; e_err[k][cyc] = 1'b0;
                e_vld[k][cyc+1] = 1'b0; e_err[k][cyc+1] = 1'b0;
            end else if (!mbusy && (rd || wr)) begin
                idx = cyc + k;
                bad = (rd && wr) || (sz == 2'b11) || ((int'(ad) % s) != 0) || (int'(ad) + s > 64);
                if (bad) begin
                    e_err[k][idx] = 1'b1;
                end else if (wr) begin
                    for (int b = 0; b < s; b++) mdl[k][int'(ad) + b] = wd[8*b +: 8];
                end else begin
                    val = '0;
                    for (int b = 0; b < s; b++) val[8*b +: 8] = mdl[k][int'(ad) + b];
                    if (!un && val[8*s-1]) val = val | (~64'h0 << (8 * s));
                    if (k == 0) val = val & 64'hFFFF_FFFF;
                    e_vld[k][idx] = 1'b1;
                    e_dat[k][idx] = val;
                end
            end
        end
        @(posedge clk);
        #1;
        o_vld[0][cyc] = b32.rd_valid; o_err[0][cyc] = b32.mem_err;
        o_busy[0][cyc] = b32.busy;    o_dat[0][cyc] = {32'h0, b32.read_data};
        o_vld[1][cyc] = b64.rd_valid; o_err[1][cyc] = b64.mem_err;
        o_busy[1][cyc] = b64.busy;    o_dat[1][cyc] = b64.read_data;
        mbusy = rst;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 64'h0, 1'b0);
    endtask

    task automatic test_reset();
        int c0 = cyc;
        cycle(1'b1, 1'b1, 1'b0, 2'b10, 32'h0, 64'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 64'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_busy[k][cyc-1] !== 1'b1 || o_vld[k][cyc-1] !== 1'b0 ||
                o_err[k][cyc-1] !== 1'b0 || o_dat[k][cyc-1] !== 64'h0) begin
                errors++;
                $display("FAIL reset_state k%0d busy/vld/err got %b%b%b dat %h want 100 dat 0",
                         k, o_busy[k][cyc-1], o_vld[k][cyc-1], o_err[k][cyc-1], o_dat[k][cyc-1]);
            end
        end
        idle(1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_busy[k][cyc-1] !== 1'b0) begin
                errors++;
                $display("FAIL busy_release k%0d got %b want 0", k, o_busy[k][cyc-1]);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 64'h0, 1'b0);
        idle(2);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_vld[k][cyc-3+k] !== 1'b1 || o_dat[k][cyc-3+k] !== 64'h0) begin
                errors++;
                $display("FAIL reset_load k%0d vld %b dat %h want 1 dat 0", k, o_vld[k][cyc-3+k], o_dat[k][cyc-3+k]);
            end
        end
        for (int c = c0; c < cyc; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_vld[k][c] !== e_vld[k][c] || o_err[k][c] !== e_err[k][c] || o_busy[k][c] !== e_busy[c] ||
                    (e_vld[k][c] && o_dat[k][c] !== e_dat[k][c])) begin
                    errors++;
                    $display("FAIL reset_model k%0d cyc %0d got v%b e%b b%b %h want v%b e%b b%b %h", k, c,
                             o_vld[k][c], o_err[k][c], o_busy[k][c], o_dat[k][c], e_vld[k][c], e_err[k][c], e_busy[c], e_dat[k][c]);
                end
            end
    endtask

    task automatic test_store_load();
        int c0 = cyc;
        logic [63:0] x32 [3];
        logic [63:0] x64 [3];
        x32 = '{64'hFFFF_FFAB, 64'h0000_00AB, 64'hFFFF_8001};
        x64 = '{64'hFFFF_FFFF_FFFF_FFAB, 64'h0000_0000_0000_00AB, 64'hFFFF_FFFF_FFFF_8001};
        cycle(1'b0, 1'b0, 1'b1, 2'b01, 32'd4, 64'hF0AB, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'b01, 32'd6, 64'h8001, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 32'd4, 64'h8001_F0AB, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b00, 32'd4, 64'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b00, 32'd4, 64'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'd6, 64'h0, 1'b0);
        idle(2);
        checks++;
        if (o_err[1][c0+3] !== 1'b1) begin
            errors++;
            $display("FAIL wide_word_misalign err got %b want 1", o_err[1][c0+3]);
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (o_vld[0][c0+3+j] !== 1'b1 || o_dat[0][c0+3+j] !== x32[j]) begin
                errors++;
                $display("FAIL ext32_%0d vld %b dat %h want 1 %h", j, o_vld[0][c0+3+j], o_dat[0][c0+3+j], x32[j]);
            end
            checks++;
            if (o_vld[1][c0+4+j] !== 1'b1 || o_dat[1][c0+4+j] !== x64[j]) begin
                errors++;
                $display("FAIL ext64_%0d vld %b dat %h want 1 %h", j, o_vld[1][c0+4+j], o_dat[1][c0+4+j], x64[j]);
            end
        end
        for (int c = c0; c < cyc; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_vld[k][c] !== e_vld[k][c] || o_err[k][c] !== e_err[k][c] || o_busy[k][c] !== e_busy[c] ||
                    (e_vld[k][c] && o_dat[k][c] !== e_dat[k][c])) begin
                    errors++;
                    $display("FAIL store_load_model k%0d cyc %0d got v%b e%b %h want v%b e%b %h", k, c,
                             o_vld[k][c], o_err[k][c], o_dat[k][c], e_vld[k][c], e_err[k][c], e_dat[k][c]);
                end
            end
    endtask

    task automatic test_back_to_back();
        int c0 = cyc;
        logic [63:0] xv [4];
        xv = '{64'h5A00, 64'h5A, 64'h5A00, 64'h5A00};
        cycle(1'b0, 1'b0, 1'b1, 2'b00, 32'd9, 64'h5A, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'd8, 64'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b00, 32'd9, 64'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'd8, 64'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'd8, 64'h0, 1'b0);
        idle(2);
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_vld[k][c0+1+j+k] !== 1'b1 || o_dat[k][c0+1+j+k] !== xv[j]) begin
                    errors++;
                    $display("FAIL b2b_%0d k%0d vld %b dat %h want 1 %h", j, k, o_vld[k][c0+1+j+k], o_dat[k][c0+1+j+k], xv[j]);
                end
            end
        for (int c = c0; c < cyc; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_vld[k][c] !== e_vld[k][c] || o_err[k][c] !== e_err[k][c] ||
                    (e_vld[k][c] && o_dat[k][c] !== e_dat[k][c])) begin
                    errors++;
                    $display("FAIL b2b_model k%0d cyc %0d got v%b e%b %h want v%b e%b %h", k, c,
                             o_vld[k][c], o_err[k][c], o_dat[k][c], e_vld[k][c], e_err[k][c], e_dat[k][c]);
                end
            end
    endtask

    task automatic test_errors();
        int c0 = cyc;
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'd2, 64'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'd1, 64'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'd62, 64'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b11, 32'd0, 64'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 2'b10, 32'd56, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'd56, 64'h0, 1'b0);
        idle(2);
        for (int j = 0; j < 5; j++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_err[k][c0+j+k] !== 1'b1 || o_vld[k][c0+j+k] !== 1'b0 || o_dat[k][c0+j+k] !== 64'h5A00) begin
                    errors++;
                    $display("FAIL err_%0d k%0d err %b vld %b dat %h want 1 0 5a00", j, k,
                             o_err[k][c0+j+k], o_vld[k][c0+j+k], o_dat[k][c0+j+k]);
                end
            end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_vld[k][c0+5+k] !== 1'b1 || o_dat[k][c0+5+k] !== 64'h0) begin
                errors++;
                $display("FAIL err_untouched k%0d vld %b dat %h want 1 0", k, o_vld[k][c0+5+k], o_dat[k][c0+5+k]);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        int c0 = cyc;
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 32'd16, 64'h5566_7788_1122_3344, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'd16, 64'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 64'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 64'h0, 1'b0);
        idle(1);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'd16, 64'h0, 1'b0);
        idle(2);
        for (int c = c0 + 2; c < c0 + 5; c++) begin
            checks++;
            if (o_vld[1][c] !== 1'b0 || o_err[1][c] !== 1'b0) begin
                errors++;
                $display("FAIL flight_discard cyc %0d vld %b err %b want 0 0", c, o_vld[1][c], o_err[1][c]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_vld[k][c0+5+k] !== 1'b1 || o_dat[k][c0+5+k] !== 64'h0) begin
                errors++;
                $display("FAIL flight_cleared k%0d vld %b dat %h want 1 0", k, o_vld[k][c0+5+k], o_dat[k][c0+5+k]);
            end
        end
        for (int c = c0; c < cyc; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_vld[k][c] !== e_vld[k][c] || o_err[k][c] !== e_err[k][c] || o_busy[k][c] !== e_busy[c]) begin
                    errors++;
                    $display("FAIL flight_model k%0d cyc %0d got v%b e%b b%b want v%b e%b b%b", k, c,
                             o_vld[k][c], o_err[k][c], o_busy[k][c], e_vld[k][c], e_err[k][c], e_busy[c]);
                end
            end
    endtask

    task automatic test_wide64();
        int c0 = cyc;
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 32'd8, 64'h0123_4567_89AB_CDEF, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'd8, 64'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b10, 32'd4, 64'h0, 1'b0);
        idle(2);
        checks++;
        if (o_vld[1][c0+2] !== 1'b1 || o_dat[1][c0+2] !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL wide_readback vld %b dat %h want 1 0123456789abcdef", o_vld[1][c0+2], o_dat[1][c0+2]);
        end
        checks++;
        if (o_err[1][c0+3] !== 1'b1 || o_vld[1][c0+3] !== 1'b0) begin
            errors++;
            $display("FAIL wide_misalign err %b vld %b want 1 0", o_err[1][c0+3], o_vld[1][c0+3]);
        end
        checks++;
        if (o_vld[0][c0+1] !== 1'b1 || o_dat[0][c0+1] !== 64'h89AB_CDEF) begin
            errors++;
            $display("FAIL narrow_readback vld %b dat %h want 1 89abcdef", o_vld[0][c0+1], o_dat[0][c0+1]);
        end
    endtask

    task automatic test_random();
        int c0 = cyc;
        int op;
        logic [31:0] ad;
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            ad = $urandom_range(0, 71);
            if ($urandom_range(0, 2) != 0) ad = ad & 32'hFFFF_FFF8;
            cycle(1'b0, op <= 3 || op == 7, op >= 4 && op <= 7, 2'($urandom_range(0, 3)), ad,
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        idle(2);
        for (int c = c0; c < cyc; c++)
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_vld[k][c] !== e_vld[k][c] || o_err[k][c] !== e_err[k][c] ||
                    (o_vld[k][c] === 1'b1 && o_err[k][c] === 1'b1) ||
                    (e_vld[k][c] && o_dat[k][c] !== e_dat[k][c])) begin
                    errors++;
                    $display("FAIL random k%0d cyc %0d got v%b e%b %h want v%b e%b %h", k, c,
                             o_vld[k][c], o_err[k][c], o_dat[k][c], e_vld[k][c], e_err[k][c], e_dat[k][c]);
                end
            end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_reset_in_flight();
        test_wide64();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
